// File: rtl/fetch_seq_ctrl_if.sv
// Fetch controller bus: imem req/gnt/rvalid, decode valid/ready, next-PC and flush.
// FETCH_ALIGN_CHECK_EN adds the fetch_misalign status signal.
interface fetch_seq_ctrl_if #(
   parameter int unsigned FLUSH_VEC_W = 32
);
   logic [31:0]            pc_out;
   logic [31:0]            npc_in;
   logic                   imem_req;
   logic [31:0]            imem_addr;
   logic                   imem_gnt;
   logic                   imem_rvalid;
   logic [31:0]            imem_rdata;
   logic [31:0]            inst_out;
   logic                   inst_valid;
   logic                   inst_ready;
   logic                   flush;
   logic [FLUSH_VEC_W-1:0] flush_pc;
   logic [31:0]            fetch_cnt;
   logic                   busy;
`ifdef FETCH_ALIGN_CHECK_EN
   logic                   fetch_misalign;

   modport master (
      output pc_out, imem_req, imem_addr, inst_out, inst_valid, fetch_cnt, busy, fetch_misalign,
      input  npc_in, imem_gnt, imem_rvalid, imem_rdata, inst_ready, flush, flush_pc
   );
   modport slave (
      input  pc_out, imem_req, imem_addr, inst_out, inst_valid, fetch_cnt, busy, fetch_misalign,
      output npc_in, imem_gnt, imem_rvalid, imem_rdata, inst_ready, flush, flush_pc
   );
`else
   modport master (
      output pc_out, imem_req, imem_addr, inst_out, inst_valid, fetch_cnt, busy,
      input  npc_in, imem_gnt, imem_rvalid, imem_rdata, inst_ready, flush, flush_pc
   );
   modport slave (
      input  pc_out, imem_req, imem_addr, inst_out, inst_valid, fetch_cnt, busy,
      output npc_in, imem_gnt, imem_rvalid, imem_rdata, inst_ready, flush, flush_pc
   );
`endif
endinterface

// File: rtl/fetch_seq_ctrl.sv
// PC sequencer and instruction fetch FSM with flush redirect and in-flight drain.
// Optional PC alignment checking (ERR state, fetch_misalign) under FETCH_ALIGN_CHECK_EN.
module fetch_seq_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_3000,
   parameter int unsigned FLUSH_VEC_W = 32
) (
   input logic              clk,
   input logic              rstn,
   fetch_seq_ctrl_if.master bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   logic [2:0]             state_q, state_d;
   logic [31:0]            pc_q, pc_d;
   logic [31:0]            inst_q, inst_d;
   logic                   valid_q, valid_d;
   logic [31:0]            cnt_q, cnt_d;
   logic                   load_pc;
   logic [31:0]            load_val;
   logic [FLUSH_VEC_W-1:0] flush_tgt;

   assign flush_tgt = bus.flush_pc;

`ifdef FETCH_ALIGN_CHECK_EN
   logic misalign_q, misalign_d;
`endif

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      valid_d  = valid_q;
      cnt_d    = cnt_q;
      load_pc  = 1'b0;
      load_val = pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_d = misalign_q;
`endif
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (bus.flush) begin
               load_pc  = 1'b1;
               load_val = flush_tgt;
            end
         end
         S_REQ: begin
            if (bus.flush) begin
               load_pc  = 1'b1;
               load_val = flush_tgt;
               // a grant taken in the flush cycle still owes a response
               state_d  = bus.imem_gnt ? S_DRAIN : S_REQ;
            end else if (bus.imem_gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.flush) begin
               load_pc  = 1'b1;
               load_val = flush_tgt;
               valid_d  = 1'b0;
               state_d  = bus.imem_rvalid ? S_REQ : S_DRAIN;
            end else if (bus.imem_rvalid) begin
               inst_d  = bus.imem_rdata;
               valid_d = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (bus.flush) begin
               load_pc  = 1'b1;
               load_val = flush_tgt;
               valid_d  = 1'b0;
               state_d  = S_REQ;
            end else if (bus.inst_ready) begin
               load_pc  = 1'b1;
               load_val = bus.npc_in;
               valid_d  = 1'b0;
               cnt_d    = cnt_q + 32'd1;
               state_d  = S_REQ;
            end
         end
         S_DRAIN: begin
            if (bus.flush) begin
               load_pc  = 1'b1;
               load_val = flush_tgt;
            end
            // the stale response retires the outstanding request even on a flush cycle
            if (bus.imem_rvalid) state_d = S_REQ;
         end
`ifdef FETCH_ALIGN_CHECK_EN
         S_ERR: begin
            valid_d = 1'b0;
            if (bus.flush) begin
               load_pc    = 1'b1;
               load_val   = flush_tgt;
               state_d    = S_REQ;
               misalign_d = 1'b0;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

`ifdef FETCH_ALIGN_CHECK_EN
      if (load_pc && (load_val[1:0] != 2'b00)) begin
         state_d    = S_ERR;
         misalign_d = 1'b1;
      end
`endif
      if (load_pc) pc_d = load_val;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) misalign_q <= 1'b0;
      else       misalign_q <= misalign_d;
   end

   assign bus.fetch_misalign = misalign_q;
`endif

   assign bus.pc_out     = pc_q;
   assign bus.imem_req   = (state_q == S_REQ);
   assign bus.imem_addr  = pc_q;
   assign bus.inst_out   = inst_q;
   assign bus.inst_valid = valid_q;
   assign bus.fetch_cnt  = cnt_q;
   assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed scenarios plus a randomized memory/decode environment checked against a
// transaction-level model (expected PC stream, accept count, address-derived memory words).
module tb_fetch_seq_ctrl;

   logic clk = 1'b0;
   logic rstn;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fetch_seq_ctrl_if bus ();

   fetch_seq_ctrl #(.RESET_PC(32'h0000_3000), .FLUSH_VEC_W(32)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.master)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      bus.npc_in = '0; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
      bus.inst_ready = 1'b0; bus.flush = 1'b0; bus.flush_pc = '0;
      repeat (2) cyc();
      if (bus.pc_out !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.pc_out, 32'h0000_3000); end checks++;
      if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end checks++;
      if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.inst_valid); end checks++;
      if (bus.inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", bus.inst_out); end checks++;
      if (bus.fetch_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.fetch_cnt); end checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end checks++;
`ifdef FETCH_ALIGN_CHECK_EN
      if (bus.fetch_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", bus.fetch_misalign); end checks++;
`endif
      rstn = 1'b1;
      cyc();
      if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", bus.imem_req); end checks++;
      if (bus.imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL first_addr: got %h expected %h", bus.imem_addr, 32'h0000_3000); end checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b expected 1", bus.busy); end checks++;
   endtask

   task automatic test_basic();
      bus.inst_ready = 1'b1;
      bus.imem_gnt = 1'b1; cyc();
      bus.imem_gnt = 1'b0;
      if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL wait_req: got %b expected 0", bus.imem_req); end checks++;
      bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2008_0005; cyc();
      bus.imem_rvalid = 1'b0;
      if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.inst_valid); end checks++;
      if (bus.inst_out !== 32'h2008_0005) begin errors++; $display("FAIL basic_inst: got %h expected %h", bus.inst_out, 32'h2008_0005); end checks++;
      bus.npc_in = bus.pc_out + 32'd4; cyc();
      bus.inst_ready = 1'b0;
      if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL basic_req2: got %b expected 1", bus.imem_req); end checks++;
      if (bus.imem_addr !== 32'h0000_3004) begin errors++; $display("FAIL basic_addr2: got %h expected %h", bus.imem_addr, 32'h0000_3004); end checks++;
      if (bus.fetch_cnt !== 32'd1) begin errors++; $display("FAIL basic_cnt: got %0d expected 1", bus.fetch_cnt); end checks++;
      if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_clr: got %b expected 0", bus.inst_valid); end checks++;
   endtask

   task automatic test_gnt_stall();
      for (int i = 0; i < 6; i++) begin
         if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL stall_req[%0d]: got %b expected 1", i, bus.imem_req); end checks++;
         if (bus.imem_addr !== 32'h0000_3004) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected %h", i, bus.imem_addr, 32'h0000_3004); end checks++;
         if (i == 5) bus.imem_gnt = 1'b1;
         cyc();
      end
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA5A5_0001; cyc();
      bus.imem_rvalid = 1'b0;
   endtask

   task automatic test_ready_stall();
      bus.npc_in = 32'h0000_3008;
      for (int i = 0; i < 4; i++) begin
         if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, bus.inst_valid); end checks++;
         if (bus.inst_out !== 32'hA5A5_0001) begin errors++; $display("FAIL hold_inst[%0d]: got %h expected %h", i, bus.inst_out, 32'hA5A5_0001); end checks++;
         if (bus.pc_out !== 32'h0000_3004) begin errors++; $display("FAIL hold_pc[%0d]: got %h expected %h", i, bus.pc_out, 32'h0000_3004); end checks++;
         if (bus.fetch_cnt !== 32'd1) begin errors++; $display("FAIL hold_cnt[%0d]: got %0d expected 1", i, bus.fetch_cnt); end checks++;
         cyc();
      end
      bus.inst_ready = 1'b1; cyc();
      bus.inst_ready = 1'b0;
      if (bus.fetch_cnt !== 32'd2) begin errors++; $display("FAIL ready_cnt: got %0d expected 2", bus.fetch_cnt); end checks++;
      if (bus.pc_out !== 32'h0000_3008) begin errors++; $display("FAIL ready_pc: got %h expected %h", bus.pc_out, 32'h0000_3008); end checks++;
      cyc();
      if (bus.fetch_cnt !== 32'd2) begin errors++; $display("FAIL ready_cnt_once: got %0d expected 2", bus.fetch_cnt); end checks++;
   endtask

   task automatic test_flush_wait();
      bus.imem_gnt = 1'b1; cyc();
      bus.imem_gnt = 1'b0; bus.flush = 1'b1; bus.flush_pc = 32'h0000_3100; cyc();
      bus.flush = 1'b0;
      if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL drain_req: got %b expected 0", bus.imem_req); end checks++;
      if (bus.pc_out !== 32'h0000_3100) begin errors++; $display("FAIL drain_pc: got %h expected %h", bus.pc_out, 32'h0000_3100); end checks++;
      cyc();
      bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; cyc();
      bus.imem_rvalid = 1'b0;
      if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL redirect_req: got %b expected 1", bus.imem_req); end checks++;
      if (bus.imem_addr !== 32'h0000_3100) begin errors++; $display("FAIL redirect_addr: got %h expected %h", bus.imem_addr, 32'h0000_3100); end checks++;
      if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL stale_valid: got %b expected 0", bus.inst_valid); end checks++;
      if (bus.inst_out !== 32'hA5A5_0001) begin errors++; $display("FAIL stale_inst: got %h expected %h", bus.inst_out, 32'hA5A5_0001); end checks++;
      bus.imem_gnt = 1'b1; cyc();
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1111_3100; cyc();
      bus.imem_rvalid = 1'b0;
      if (bus.inst_out !== 32'h1111_3100) begin errors++; $display("FAIL redirect_inst: got %h expected %h", bus.inst_out, 32'h1111_3100); end checks++;
      bus.inst_ready = 1'b1; bus.npc_in = 32'h0000_3104; cyc();
      bus.inst_ready = 1'b0;
      if (bus.fetch_cnt !== 32'd3) begin errors++; $display("FAIL redirect_cnt: got %0d expected 3", bus.fetch_cnt); end checks++;
   endtask

   task automatic test_flush_hold();
      bus.imem_gnt = 1'b1; cyc();
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2222_3104; cyc();
      bus.imem_rvalid = 1'b0;
      if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL fh_valid: got %b expected 1", bus.inst_valid); end checks++;
      bus.inst_ready = 1'b1; bus.npc_in = 32'h0000_3008; bus.flush = 1'b1; bus.flush_pc = 32'h0000_3200; cyc();
      bus.inst_ready = 1'b0; bus.flush = 1'b0;
      if (bus.pc_out !== 32'h0000_3200) begin errors++; $display("FAIL fh_pc: got %h expected %h", bus.pc_out, 32'h0000_3200); end checks++;
      if (bus.fetch_cnt !== 32'd3) begin errors++; $display("FAIL fh_cnt: got %0d expected 3", bus.fetch_cnt); end checks++;
      if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL fh_valid_clr: got %b expected 0", bus.inst_valid); end checks++;
      if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL fh_req: got %b expected 1", bus.imem_req); end checks++;
   endtask

`ifdef FETCH_ALIGN_CHECK_EN
   task automatic test_misalign();
      if (bus.fetch_misalign !== 1'b0) begin errors++; $display("FAIL ma_pre: got %b expected 0", bus.fetch_misalign); end checks++;
      bus.imem_gnt = 1'b1; cyc();
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h3333_3200; cyc();
      bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b1; bus.npc_in = 32'h0000_3006; cyc();
      bus.inst_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bus.fetch_misalign !== 1'b1) begin errors++; $display("FAIL ma_flag[%0d]: got %b expected 1", i, bus.fetch_misalign); end checks++;
         if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL ma_req[%0d]: got %b expected 0", i, bus.imem_req); end checks++;
         if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL ma_valid[%0d]: got %b expected 0", i, bus.inst_valid); end checks++;
         if (bus.pc_out !== 32'h0000_3006) begin errors++; $display("FAIL ma_pc[%0d]: got %h expected %h", i, bus.pc_out, 32'h0000_3006); end checks++;
         bus.imem_rvalid = (i == 1);
         cyc();
      end
      bus.imem_rvalid = 1'b0;
      bus.flush = 1'b1; bus.flush_pc = 32'h0000_3402; cyc();
      bus.flush = 1'b0;
      if (bus.fetch_misalign !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL ma_bad_flush: got flag=%b req=%b expected flag=1 req=0", bus.fetch_misalign, bus.imem_req); end checks++;
      bus.flush = 1'b1; bus.flush_pc = 32'h0000_3400; cyc();
      bus.flush = 1'b0;
      if (bus.fetch_misalign !== 1'b0) begin errors++; $display("FAIL ma_clear: got %b expected 0", bus.fetch_misalign); end checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3400) begin errors++; $display("FAIL ma_resume: got req=%b addr=%h expected req=1 addr=%h", bus.imem_req, bus.imem_addr, 32'h0000_3400); end checks++;
   endtask
`endif

   task automatic test_async_reset();
      bus.imem_gnt = 1'b1; cyc();
      bus.imem_gnt = 1'b0;
      #2 rstn = 1'b0;
      #1;
      if (bus.pc_out !== 32'h0000_3000) begin errors++; $display("FAIL ar_pc: got %h expected %h", bus.pc_out, 32'h0000_3000); end checks++;
      if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ar_ctrl: got req=%b valid=%b busy=%b expected 0 0 0", bus.imem_req, bus.inst_valid, bus.busy); end checks++;
      if (bus.inst_out !== 32'h0) begin errors++; $display("FAIL ar_inst: got %h expected 0", bus.inst_out); end checks++;
      if (bus.fetch_cnt !== 32'h0) begin errors++; $display("FAIL ar_cnt: got %0d expected 0", bus.fetch_cnt); end checks++;
      cyc();
      rstn = 1'b1; cyc();
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3000) begin errors++; $display("FAIL ar_restart: got req=%b addr=%h expected req=1 addr=%h", bus.imem_req, bus.imem_addr, 32'h0000_3000); end checks++;
   endtask

   task automatic test_random();
      logic [31:0] exp_pc = 32'h0000_3000;
      logic [31:0] exp_cnt = '0;
      logic [31:0] out_addr = '0;
      logic [31:0] r;
      bit          outstanding = 1'b0;
      int          dly = 0;
      int          idle = 0;
      for (int c = 0; c < 3000; c++) begin
         if (bus.pc_out !== exp_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h expected %h", c, bus.pc_out, exp_pc); end checks++;
         if (bus.fetch_cnt !== exp_cnt) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d expected %0d", c, bus.fetch_cnt, exp_cnt); end checks++;
         if (bus.imem_req && bus.imem_addr !== exp_pc) begin errors++; $display("FAIL rnd_addr@%0d: got %h expected %h", c, bus.imem_addr, exp_pc); end checks++;
         if (bus.inst_valid && bus.inst_out !== mem_word(bus.pc_out)) begin errors++; $display("FAIL rnd_inst@%0d: got %h expected %h", c, bus.inst_out, mem_word(bus.pc_out)); end checks++;
         if (bus.imem_req && outstanding) begin errors++; $display("FAIL rnd_req_outstanding@%0d: got req=1 expected 0", c); end checks++;
         if (bus.busy !== 1'b1) begin errors++; $display("FAIL rnd_busy@%0d: got %b expected 1", c, bus.busy); end checks++;

         if (outstanding) begin
            if (dly == 0) begin
               bus.imem_rvalid = 1'b1; bus.imem_rdata = mem_word(out_addr); outstanding = 1'b0;
            end else begin
               bus.imem_rvalid = 1'b0; dly--;
            end
         end else begin
            bus.imem_rvalid = ($urandom_range(0, 7) == 0); bus.imem_rdata = $urandom;
         end
         bus.imem_gnt = bus.imem_req && ($urandom_range(0, 2) == 0);
         if (bus.imem_gnt) begin
            outstanding = 1'b1; out_addr = bus.imem_addr; dly = $urandom_range(0, 2);
         end
         bus.inst_ready = ($urandom_range(0, 2) != 0);
         r = $urandom; r[1:0] = 2'b00;
         bus.npc_in = ($urandom_range(0, 3) == 0) ? r : bus.pc_out + 32'd4;
         bus.flush = ($urandom_range(0, 15) == 0);
         r = $urandom; r[1:0] = 2'b00;
         bus.flush_pc = r;

         if (bus.flush) begin
            exp_pc = bus.flush_pc; idle = 0;
         end else if (bus.inst_valid && bus.inst_ready) begin
            exp_pc = bus.npc_in; exp_cnt = exp_cnt + 32'd1; idle = 0;
         end else begin
            idle++;
         end
         if (idle > 200) begin
            errors++; checks++;
            $display("FAIL rnd_watchdog@%0d: got no progress for %0d cycles expected progress", c, idle);
            break;
         end
         cyc();
      end
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b0; bus.flush = 1'b0;
      if (exp_cnt < 32'd100) begin errors++; $display("FAIL rnd_throughput: got %0d accepts expected at least 100", exp_cnt); end checks++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gnt_stall();
      test_ready_stall();
      test_flush_wait();
      test_flush_hold();
`ifdef FETCH_ALIGN_CHECK_EN
      test_misalign();
`endif
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
Sequences the program counter and instruction fetch for the multi-cycle CPU. Holds the architectural PC and issues requests to instruction memory over a req/gnt/rvalid handshake. Presents each fetched instruction to decode with a valid/ready handshake, then loads the next PC from the next-PC unit. Also handles flush redirects, including discarding an in-flight response.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
FLUSH_VEC_W, 32, width of flush target address; fixed at 32

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
pc_out  out  32  PC of the instruction currently being fetched or held
npc_in  in  32  next PC from the next-PC unit, computed from pc_out
imem_req  out  1  instruction memory request
imem_addr  out  32  request address; equals pc_out while imem_req=1
imem_gnt  in  1  memory accepted the request this cycle
imem_rvalid  in  1  response data valid, one pulse per granted request
imem_rdata  in  32  response instruction word
inst_out  out  32  buffered instruction to decode
inst_valid  out  1  inst_out holds a valid instruction
inst_ready  in  1  decode consumes inst_out this cycle
flush  in  1  redirect request, single-cycle pulse
flush_pc  in  32  redirect target
fetch_cnt  out  32  count of instructions accepted by decode
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rstn=0, asynchronous): pc_out=RESET_PC, state=IDLE, imem_req=0, inst_valid=0, inst_out=0, fetch_cnt=0, busy=0.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE: entered from reset. Goes to REQ on the first clock with rstn=1.
- REQ: imem_req=1 and imem_addr=pc_out. Stays in REQ until imem_gnt=1, then goes to WAIT. imem_req is deasserted in WAIT/HOLD/DRAIN.
- WAIT: on imem_rvalid=1, inst_out<=imem_rdata, inst_valid<=1, go to HOLD.
- HOLD: inst_valid=1 and inst_out stable until inst_ready=1. On inst_ready:
  - inst_valid<=0
  - pc_out<=npc_in
  - fetch_cnt<=fetch_cnt+1, wrapping modulo 2^32
  - go to REQ
  Fetch-to-issue latency is therefore at least 3 clocks per instruction (REQ, WAIT, HOLD) with gnt and rvalid each taking one cycle.
- flush=1 has priority over every other event in the same cycle:
  - pc_out<=flush_pc and inst_valid<=0; fetch_cnt is not incremented even if inst_ready=1.
  - From IDLE/REQ/HOLD: go to REQ. A grant coinciding with flush in REQ is treated as outstanding: go to DRAIN instead.
  - From WAIT with imem_rvalid=0: go to DRAIN.
  - From WAIT with imem_rvalid=1 in the same cycle: the response is dropped; go to REQ.
- DRAIN: imem_req=0. Wait for imem_rvalid, discard imem_rdata, go to REQ.
  - A second flush in DRAIN updates pc_out and stays in DRAIN.
- imem_rvalid outside WAIT/DRAIN is ignored.
- pc_out changes only on HOLD->REQ, on flush, or on reset.
- busy=1 in every state except IDLE.
- No combinational path from inputs to imem_req/inst_valid; both are decoded from registered state.

Optional Feature:
Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0) and state ERR.
  - On any load of pc_out (npc_in or flush_pc) whose bits [1:0]!=0, the PC is still loaded, but the FSM goes to ERR instead of REQ. fetch_misalign<=1.
  - ERR issues no requests and holds inst_valid=0.
  - Only a flush with an aligned flush_pc leaves ERR (to REQ) and clears fetch_misalign.
- Not defined: no checking. Bits [1:0] pass through to imem_addr unchanged, and no extra port exists.

Test Plan:
- Reset release, gnt and rvalid each one cycle after request, rdata=32'h2008_0005, inst_ready tied 1, npc_in=pc_out+4 -> first imem_addr=32'h0000_3000, inst_out=32'h2008_0005, next imem_addr=32'h0000_3004, fetch_cnt=1.
- imem_gnt held low 5 cycles -> imem_req/imem_addr stable for 6 cycles; then normal completion.
- inst_ready low 4 cycles in HOLD -> inst_valid=1 and inst_out stable; pc_out unchanged; fetch_cnt increments exactly once on ready.
- Flush in WAIT with flush_pc=32'h0000_3100, stale rvalid 2 cycles later -> stale data never appears on inst_out; next imem_addr=32'h0000_3100.
- Flush and inst_ready in the same HOLD cycle, npc_in=32'h0000_3008, flush_pc=32'h0000_3200 -> pc_out=32'h0000_3200, fetch_cnt unchanged.
- rstn asserted mid-WAIT -> all outputs return to reset values immediately (asynchronously); the fetch restarts at RESET_PC. With FETCH_ALIGN_CHECK_EN, npc_in=32'h0000_3006 -> fetch_misalign=1 and no imem_req until an aligned flush.
